reg_bank_wb: RTL and testbench

//   Parametrised general-purpose register bank for the pipelined CPU. It generalises the single 8-bit register.
//   - DEPTH registers of WIDTH bits.
//   - One active-low write port and two combinational read ports (A/B operand fetch).
//   - Writes pass through a one-entry write-back staging register before they commit to the array.
//   - Sits between decode (read) and write-back (write) stages.
//

---
 rtl/reg_bank_wb.sv | 81 ++++++++
 tb/tb_reg_bank_wb.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/reg_bank_wb.sv
// General-purpose register bank with one active-low write port, two combinational
// read ports and a one-entry write-back staging register. Define REG_BANK_BYPASS_EN
// to forward the staged write to the read ports.
module reg_bank_wb #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_load_n,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_a_addr,
  output logic [WIDTH-1:0]         rd_a_data,
  input  logic [$clog2(DEPTH)-1:0] rd_b_addr,
  output logic [WIDTH-1:0]         rd_b_data,
  output logic                     wr_pending
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wb_valid_q, wb_valid_d;
  logic [AW-1:0]    wb_addr_q, wb_addr_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;

  // A write to the hardwired zero register is dropped at capture, so it never
  // reaches the staging register and never raises wr_pending.
  always_comb begin
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    if (!wr_load_n && !((ZERO_REG != 0) && (wr_addr == '0))) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = wr_addr;
      wb_data_d  = wr_data;
    end
  end

  // Commit of the staged write and capture of the next one share the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      if (wb_valid_q) begin
        mem_q[wb_addr_q] <= wb_data_q;
      end
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] addr);
    logic [WIDTH-1:0] val;
    val = mem_q[addr];
`ifdef REG_BANK_BYPASS_EN
    if (wb_valid_q && (wb_addr_q == addr)) begin
      val = wb_data_q;
    end
`endif
    if ((ZERO_REG != 0) && (addr == '0)) begin
      val = '0;
    end
    return val;
  endfunction

  always_comb begin
    rd_a_data = read_port(rd_a_addr);
    rd_b_data = read_port(rd_b_addr);
  end

  assign wr_pending = wb_valid_q;

endmodule

// File: tb/tb_reg_bank_wb.sv
// Directed bench for reg_bank_wb: default bank, a ZERO_REG=1 bank and a
// 16x16 bank; expectations follow REG_BANK_BYPASS_EN when it is defined.
module tb_reg_bank_wb;

`ifdef REG_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default bank
  logic       wr_load_n;
  logic [2:0] wr_addr, rd_a_addr, rd_b_addr;
  logic [7:0] wr_data, rd_a_data, rd_b_data;
  logic       wr_pending;

  // zero-register bank
  logic       z_wr_load_n;
  logic [2:0] z_wr_addr, z_rd_a_addr, z_rd_b_addr;
  logic [7:0] z_wr_data, z_rd_a_data, z_rd_b_data;
  logic       z_wr_pending;

  // wide bank
  logic        w_wr_load_n;
  logic [3:0]  w_wr_addr, w_rd_a_addr, w_rd_b_addr;
  logic [15:0] w_wr_data, w_rd_a_data, w_rd_b_data;
  logic        w_wr_pending;

  int n_cmp = 0;
  int n_fail = 0;

  reg_bank_wb dut (
    .clk(clk), .rst_n(rst_n), .wr_load_n(wr_load_n), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data),
    .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data), .wr_pending(wr_pending)
  );

  reg_bank_wb #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .wr_load_n(z_wr_load_n), .wr_addr(z_wr_addr),
    .wr_data(z_wr_data), .rd_a_addr(z_rd_a_addr), .rd_a_data(z_rd_a_data),
    .rd_b_addr(z_rd_b_addr), .rd_b_data(z_rd_b_data), .wr_pending(z_wr_pending)
  );

  reg_bank_wb #(.WIDTH(16), .DEPTH(16), .ZERO_REG(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .wr_load_n(w_wr_load_n), .wr_addr(w_wr_addr),
    .wr_data(w_wr_data), .rd_a_addr(w_rd_a_addr), .rd_a_data(w_rd_a_data),
    .rd_b_addr(w_rd_b_addr), .rd_b_data(w_rd_b_data), .wr_pending(w_wr_pending)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wr_load_n = 1'b1;   wr_addr = '0;   wr_data = '0;   rd_a_addr = '0;   rd_b_addr = '0;
    z_wr_load_n = 1'b1; z_wr_addr = '0; z_wr_data = '0; z_rd_a_addr = '0; z_rd_b_addr = '0;
    w_wr_load_n = 1'b1; w_wr_addr = '0; w_wr_data = '0; w_rd_a_addr = '0; w_rd_b_addr = '0;
    step();
    rst_n = 1'b1;

    // 1: random writes, then reset with a write still requested
    for (int i = 0; i < 6; i++) begin
      wr_load_n = 1'b0;
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 8'($urandom_range(1, 255));
      step();
    end
    rst_n = 1'b0;
    step();
    chk("rst_pending", 16'(wr_pending), 16'h0);
    for (int a = 0; a < 8; a++) begin
      rd_a_addr = 3'(a);
      rd_b_addr = 3'(7 - a);
      #1;
      chk($sformatf("rst_a_r%0d", a), 16'(rd_a_data), 16'h00);
      chk($sformatf("rst_b_r%0d", 7 - a), 16'(rd_b_data), 16'h00);
    end

    // 2: r3 = A5, latency and pending window
    rst_n = 1'b1;
    wr_load_n = 1'b0; wr_addr = 3'd3; wr_data = 8'hA5; rd_a_addr = 3'd3;
    step();
    wr_load_n = 1'b1;
    #1;
    chk("r3_edge1", 16'(rd_a_data), BYP ? 16'h00A5 : 16'h0000);
    chk("pend_edge1", 16'(wr_pending), 16'h1);
    step();
    chk("r3_edge2", 16'(rd_a_data), 16'h00A5);
    chk("pend_edge2", 16'(wr_pending), 16'h0);

    // 3: back-to-back r5=11, r5=22, r6=33
    rd_b_addr = 3'd5;
    wr_load_n = 1'b0; wr_addr = 3'd5; wr_data = 8'h11;
    step();
    chk("b2b_r5_c1", 16'(rd_b_data), BYP ? 16'h0011 : 16'h0000);
    chk("b2b_pend_c1", 16'(wr_pending), 16'h1);
    wr_data = 8'h22;
    step();
    chk("b2b_r5_c2", 16'(rd_b_data), BYP ? 16'h0022 : 16'h0011);
    wr_addr = 3'd6; wr_data = 8'h33;
    step();
    chk("b2b_r5_c3", 16'(rd_b_data), 16'h0022);
    wr_load_n = 1'b1;
    step();
    rd_a_addr = 3'd6;
    #1;
    chk("b2b_r6_final", 16'(rd_a_data), 16'h0033);
    chk("b2b_r5_final", 16'(rd_b_data), 16'h0022);
    chk("b2b_pend_idle", 16'(wr_pending), 16'h0);

    // 4: reset on the commit edge discards the staged write
    wr_load_n = 1'b0; wr_addr = 3'd2; wr_data = 8'h7E;
    step();
    wr_load_n = 1'b1; rst_n = 1'b0;
    step();
    rst_n = 1'b1; rd_a_addr = 3'd2;
    #1;
    chk("rst_commit_r2", 16'(rd_a_data), 16'h0000);
    chk("rst_commit_pend", 16'(wr_pending), 16'h0);
    chk("rst_commit_r5", 16'(rd_b_data), 16'h0000);

    // 6: both ports on r4 while it is being written
    rd_a_addr = 3'd4; rd_b_addr = 3'd4;
    wr_load_n = 1'b0; wr_addr = 3'd4; wr_data = 8'h5A;
    step();
    wr_load_n = 1'b1;
    #1;
    chk("same_c1_ab", 16'(rd_a_data), 16'(rd_b_data));
    chk("same_c1_a", 16'(rd_a_data), BYP ? 16'h005A : 16'h0000);
    step();
    chk("same_c2_ab", 16'(rd_a_data), 16'(rd_b_data));
    chk("same_c2_a", 16'(rd_a_data), 16'h005A);

    // 5a: ZERO_REG bank drops writes to r0, keeps r1
    z_wr_load_n = 1'b0; z_wr_addr = 3'd0; z_wr_data = 8'hFF; z_rd_a_addr = 3'd0; z_rd_b_addr = 3'd1;
    step();
    chk("zr_pend", 16'(z_wr_pending), 16'h0);
    chk("zr_r0_c1", 16'(z_rd_a_data), 16'h0000);
    z_wr_addr = 3'd1; z_wr_data = 8'hC3;
    step();
    z_wr_load_n = 1'b1;
    #1;
    chk("zr_r0_c2", 16'(z_rd_a_data), 16'h0000);
    chk("zr_r1_pend", 16'(z_wr_pending), 16'h1);
    step();
    chk("zr_r1_final", 16'(z_rd_b_data), 16'h00C3);
    chk("zr_r0_final", 16'(z_rd_a_data), 16'h0000);

    // 5b: 16x16 bank stores full-width data
    w_wr_load_n = 1'b0; w_wr_addr = 4'd15; w_wr_data = 16'hBEEF; w_rd_a_addr = 4'd15; w_rd_b_addr = 4'd14;
    step();
    w_wr_load_n = 1'b1;
    #1;
    chk("wide_r15_c1", w_rd_a_data, BYP ? 16'hBEEF : 16'h0000);
    step();
    chk("wide_r15_c2", w_rd_a_data, 16'hBEEF);
    chk("wide_r14", w_rd_b_data, 16'h0000);
    chk("wide_pend", 16'(w_wr_pending), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
